mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and drives a variable-latency data memory through a req/ack handshake. It raises `stall` to freeze the upstream pipeline registers while an access is outstanding, then loads the MEM/WB pipeline register with the write-back data. Non-memory instructions pass through in one cycle with no stall.

## Interface
Parameters:
- `WIDTH`, 16, data/address width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `alu_result_MEM`  in  WIDTH  ALU result from EX/MEM; memory address for loads and stores
- `wdata_MEM`  in  WIDTH  store data from EX/MEM
- `we_mem_MEM`  in  1  store request
- `re_mem_MEM`  in  1  load request
- `wb_sel_MEM`  in  1  write-back select, passed through
- `rf_we_MEM`  in  1  register-file write enable, passed through
- `mem_req`  out  1  memory request, held until ack
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  WIDTH  latched address
- `mem_wdata`  out  WIDTH  latched store data
- `mem_rdata`  in  WIDTH  read data, valid when `mem_ack`=1
- `mem_ack`  in  1  single-cycle access-complete pulse
- `stall`  out  1  freeze EX/MEM and earlier stages
- `wb_data_WB`  out  WIDTH  MEM/WB data: load data or ALU result
- `wb_sel_WB`  out  1  MEM/WB write-back select
- `rf_we_WB`  out  1  MEM/WB register write enable; 0 = bubble

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state: IDLE.
- `op` = `re_mem_MEM | we_mem_MEM`.
- IDLE, `op`=0: stay IDLE. MEM/WB loads `alu_result_MEM`, `wb_sel_MEM`, `rf_we_MEM`.
- IDLE, `op`=1: go to BUSY.
  - Latch `mem_addr`←`alu_result_MEM`, `mem_wdata`←`wdata_MEM`, `mem_we`←`we_mem_MEM`, and latch `re_mem_MEM`, `wb_sel_MEM`, `rf_we_MEM` internally.
  - MEM/WB loads a bubble (`rf_we_WB`←0, other WB fields hold).
- BUSY: `mem_req`=1. Each non-ack cycle loads a bubble into MEM/WB.
  - On `mem_ack`=1: capture `mem_rdata` if the latched op is a load, then go to DONE. MEM/WB still loads a bubble this cycle.
- DONE: `mem_req`=0, `stall`=0. MEM/WB loads the latched `wb_sel` and `rf_we`.
  - `wb_data_WB`← captured read data for a load, latched address (ALU result) for a store.
  - Always go to IDLE. No new access is started from DONE, so the same instruction is never issued twice.
- `stall` = (IDLE & `op`) | BUSY. This is combinational from state and inputs.
- `re_mem_MEM` and `we_mem_MEM` both 1: treated as a write. `mem_we`=1, and no read data is captured.
- `mem_ack` while `mem_req`=0 (IDLE/DONE): ignored, no state change.
- `mem_addr`, `mem_wdata`, `mem_we` stay constant for the whole BUSY period.

## Timing
- Reset (async, immediate): state IDLE; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `wb_data_WB`=0, `wb_sel_WB`=0, `rf_we_WB`=0, internal latches 0. `stall` is 0 after reset unless `op`=1 on the inputs.
- Reset during BUSY aborts the access: `mem_req` falls asynchronously and the in-flight result is discarded.
- Non-memory instruction: latency 1 (MEM/WB valid at the next edge). `stall`=0.
- Memory access, ack in the first BUSY cycle:
  - cycle 0 IDLE, `stall`=1;
  - cycle 1 BUSY with `mem_req`=1 and ack, `stall`=1;
  - cycle 2 DONE, `stall`=0;
  - MEM/WB valid after the cycle-2 edge.
- Each extra wait cycle before `mem_ack` adds one BUSY cycle and one stall cycle. Minimum stall is 2 cycles.
- `mem_req` rises on the edge leaving IDLE and falls on the edge after `mem_ack`.
- `rf_we_WB` is 1 for exactly one cycle per completed instruction that has `rf_we`=1.

## Test plan
- Reset: assert `rst_n`=0 mid-BUSY -> `mem_req`=0 and `rf_we_WB`=0 immediately, and state returns to IDLE. After release, with `op`=0, `stall`=0.
- ALU pass-through: `alu_result_MEM`=16'h1234, `rf_we_MEM`=1, `op`=0 -> next cycle `wb_data_WB`=16'h1234 and `rf_we_WB`=1. `stall` never asserts.
- Load with 0 wait states: `re_mem_MEM`=1, addr 16'h00A0, `rf_we_MEM`=1, memory acks in the first BUSY cycle with rdata 16'hBEEF.
  - `stall`=1 for exactly 2 cycles; `mem_addr`=16'h00A0 and `mem_we`=0 during BUSY.
  - Then `wb_data_WB`=16'hBEEF with `rf_we_WB`=1 for 1 cycle.
- Store with 3 wait states: `we_mem_MEM`=1, addr 16'h0010, data 16'h5A5A.
  - `mem_req`=1 for 4 cycles with constant address and data; `stall`=1 for 5 cycles.
  - `rf_we_WB` follows `rf_we_MEM`=0 (stays 0).
- Back-to-back loads, ack delays 0 and 2: each address is issued exactly once.
  - Total `stall`-high cycles = 2 + 4.
  - Two single-cycle `rf_we_WB` pulses carrying the correct data in order.
- Spurious `mem_ack` in IDLE plus simultaneous `re`=`we`=1 -> ack ignored, and the access is issued as a write (`mem_we`=1).

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller. Issues loads/stores to a variable-
// latency data memory over a req/ack handshake, stalls the front of the
// pipeline while an access is in flight, and loads the MEM/WB register.
module mem_stage_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_result_MEM,
    input  logic [WIDTH-1:0] wdata_MEM,
    input  logic             we_mem_MEM,
    input  logic             re_mem_MEM,
    input  logic             wb_sel_MEM,
    input  logic             rf_we_MEM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             stall,
    output logic [WIDTH-1:0] wb_data_WB,
    output logic             wb_sel_WB,
    output logic             rf_we_WB
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             op;
    logic             ld_q;      // latched op is a pure load (re & ~we)
    logic             wb_sel_q;
    logic             rf_we_q;
    logic [WIDTH-1:0] rdata_q;

    assign op = re_mem_MEM | we_mem_MEM;

    // Freeze upstream while an access is being started or is outstanding;
    // DONE releases the stall so EX/MEM advances past this instruction.
    always_comb begin
        stall = ((state == IDLE) && op) || (state == BUSY);
    end

    // Access FSM, memory-side latches and MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ld_q       <= 1'b0;
            wb_sel_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rdata_q    <= '0;
            wb_data_WB <= '0;
            wb_sel_WB  <= 1'b0;
            rf_we_WB   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
                        // Start the access; re & we together is a write.
                        state     <= BUSY;
                        mem_req   <= 1'b1;
                        mem_addr  <= alu_result_MEM;
                        mem_wdata <= wdata_MEM;
                        mem_we    <= we_mem_MEM;
                        ld_q      <= re_mem_MEM & ~we_mem_MEM;
                        wb_sel_q  <= wb_sel_MEM;
                        rf_we_q   <= rf_we_MEM;
                        rf_we_WB  <= 1'b0;
                    end else begin
                        // Non-memory instruction passes straight through.
                        wb_data_WB <= alu_result_MEM;
                        wb_sel_WB  <= wb_sel_MEM;
                        rf_we_WB   <= rf_we_MEM;
                    end
                end
                BUSY: begin
                    rf_we_WB <= 1'b0;
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (ld_q) rdata_q <= mem_rdata;
                    end
                end
                DONE: begin
                    // Retire the access; never re-issue from here.
                    state      <= IDLE;
                    wb_data_WB <= ld_q ? rdata_q : mem_addr;
                    wb_sel_WB  <= wb_sel_q;
                    rf_we_WB   <= rf_we_q;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed vectors for mem_stage_ctrl with hand-computed
// expected write-back data, stall counts and request counts.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] alu_result_MEM, wdata_MEM, mem_rdata;
    logic        we_mem_MEM, re_mem_MEM, wb_sel_MEM, rf_we_MEM, mem_ack;
    logic        mem_req, mem_we, stall, wb_sel_WB, rf_we_WB;
    logic [15:0] mem_addr, mem_wdata, wb_data_WB;

    int n_vec = 0;
    int n_err = 0;
    int s0, r0, s1, r1;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result_MEM(alu_result_MEM), .wdata_MEM(wdata_MEM),
        .we_mem_MEM(we_mem_MEM), .re_mem_MEM(re_mem_MEM),
        .wb_sel_MEM(wb_sel_MEM), .rf_we_MEM(rf_we_MEM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .wb_data_WB(wb_data_WB), .wb_sel_WB(wb_sel_WB),
        .rf_we_WB(rf_we_WB)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        alu_result_MEM = '0; wdata_MEM = '0; we_mem_MEM = 0; re_mem_MEM = 0;
        wb_sel_MEM = 0; rf_we_MEM = 0;
    endtask

    // Present one memory instruction (held until DONE), play the memory side
    // with 'waits' non-ack BUSY cycles, count stall and req cycles.
    // Entered and left at posedge+1.
    task automatic do_access(input logic [15:0] addr, input logic [15:0] wd,
                             input logic re, input logic we, input logic rfw,
                             input logic wbs, input int waits,
                             input logic [15:0] rd, input logic spur,
                             output int n_stall, output int n_req);
        bit seen = 0;
        bit done = 0;
        n_stall = 0; n_req = 0;
        alu_result_MEM = addr; wdata_MEM = wd; re_mem_MEM = re; we_mem_MEM = we;
        rf_we_MEM = rfw; wb_sel_MEM = wbs;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) n_stall++;
            if (mem_req) begin
                seen = 1;
                n_req++;
                chk("busy_addr", mem_addr, addr);
                chk("busy_wdata", mem_wdata, wd);
                chk("busy_we", mem_we, we);
                chk("busy_bubble", rf_we_WB, 0);
                mem_ack   = (n_req == waits + 1);
                mem_rdata = mem_ack ? rd : 16'hDEAD;
            end else begin
                mem_ack   = spur && !seen;
                mem_rdata = 16'hDEAD;
                if (seen) done = 1;
            end
            @(posedge clk);
        end
        chk("access_done", done, 1);
        mem_ack = 0;
        idle_in();
        #1;
    endtask

    initial begin
        rst_n = 0; mem_ack = 0; mem_rdata = '0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rfwe", rf_we_WB, 0);
        chk("rst_wbdata", wb_data_WB, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        rst_n = 1;
        tick();

        // ALU pass-through
        alu_result_MEM = 16'h1234; rf_we_MEM = 1; wb_sel_MEM = 1;
        #1 chk("alu_stall", stall, 0);
        tick();
        chk("alu_wbdata", wb_data_WB, 16'h1234);
        chk("alu_rfwe", rf_we_WB, 1);
        chk("alu_wbsel", wb_sel_WB, 1);
        chk("alu_stall2", stall, 0);
        idle_in();
        tick();
        chk("alu_rfwe_off", rf_we_WB, 0);

        // Load, 0 wait states
        do_access(16'h00A0, 16'h0000, 1, 0, 1, 1, 0, 16'hBEEF, 0, s0, r0);
        chk("ld0_stall", s0, 2);
        chk("ld0_req", r0, 1);
        chk("ld0_wbdata", wb_data_WB, 16'hBEEF);
        chk("ld0_rfwe", rf_we_WB, 1);
        tick();
        chk("ld0_pulse", rf_we_WB, 0);

        // Store, 3 wait states
        do_access(16'h0010, 16'h5A5A, 0, 1, 0, 0, 3, 16'h9999, 0, s0, r0);
        chk("st3_stall", s0, 5);
        chk("st3_req", r0, 4);
        chk("st3_rfwe", rf_we_WB, 0);
        chk("st3_wbdata", wb_data_WB, 16'h0010);
        tick();
        chk("st3_rfwe2", rf_we_WB, 0);

        // Back-to-back loads, ack delays 0 and 2
        do_access(16'h0100, 16'h0000, 1, 0, 1, 1, 0, 16'h1111, 0, s0, r0);
        chk("b2b_wb1", wb_data_WB, 16'h1111);
        chk("b2b_rfwe1", rf_we_WB, 1);
        do_access(16'h0102, 16'h0000, 1, 0, 1, 1, 2, 16'h2222, 0, s1, r1);
        chk("b2b_stall_total", s0 + s1, 6);
        chk("b2b_req1", r0, 1);
        chk("b2b_req2", r1, 3);
        chk("b2b_wb2", wb_data_WB, 16'h2222);
        chk("b2b_rfwe2", rf_we_WB, 1);
        tick();
        chk("b2b_pulse", rf_we_WB, 0);

        // Spurious ack in IDLE with op=0: ignored
        mem_ack = 1; mem_rdata = 16'hCCCC;
        #1 chk("spur_stall", stall, 0);
        tick();
        mem_ack = 0;
        chk("spur_req", mem_req, 0);
        chk("spur_rfwe", rf_we_WB, 0);

        // re=we=1 treated as write; spurious ack alongside the IDLE cycle
        do_access(16'h0040, 16'h7777, 1, 1, 1, 0, 1, 16'hCCCC, 1, s0, r0);
        chk("rw_req", r0, 2);
        chk("rw_stall", s0, 3);
        chk("rw_wbdata", wb_data_WB, 16'h0040);
        chk("rw_rfwe", rf_we_WB, 1);
        tick();

        // Reset during BUSY aborts the access
        alu_result_MEM = 16'h0200; re_mem_MEM = 1; rf_we_MEM = 1;
        tick();
        chk("abort_busy_req", mem_req, 1);
        #2 rst_n = 0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_rfwe", rf_we_WB, 0);
        idle_in();
        #1 chk("abort_stall_in_rst", stall, 0);
        rst_n = 1;
        tick();
        chk("abort_idle_req", mem_req, 0);
        chk("abort_idle_stall", stall, 0);
        chk("abort_wbdata", wb_data_WB, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
